// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared types and helpers for the data-memory responder
package dmem_responder_pkg;
  localparam int N_BITS = 32;
  typedef enum logic [1:0] {
    DMEM_LEN_B = 2'd0,
    DMEM_LEN_H = 2'd1,
    DMEM_LEN_W = 2'd2
  } dmem_len_e;
  typedef struct packed {
    logic       vld;
    logic       mtype;
    logic [1:0] len;
  } dmem_req_ctrl_t;
  typedef struct packed {
    logic [N_BITS-1:0] data;
    logic              err;
  } dmem_resp_t;
  function automatic logic [3:0] lane_be(logic [1:0] len, logic [1:0] off);
    return len == DMEM_LEN_B ? 4'b0001 << off :
           len == DMEM_LEN_H ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: LSU request/response bus between core and data-memory responder
interface dmem_responder_if;
  import dmem_responder_pkg::*;
  dmem_req_ctrl_t    req_ctrl;
  logic [N_BITS-1:0] req_addr;
  logic [N_BITS-1:0] req_wdata;
  logic              req_rdy;
  logic              resp_vld;
  logic [N_BITS-1:0] resp_data;
  logic              resp_err;
  logic              resp_rdy;
  modport master (output req_ctrl, req_addr, req_wdata, resp_rdy,
                  input  req_rdy, resp_vld, resp_data, resp_err);
  modport slave  (input  req_ctrl, req_addr, req_wdata, resp_rdy,
                  output req_rdy, resp_vld, resp_data, resp_err);
endinterface

// File: rtl/dmem_responder_fifo.sv
// dmem_responder_fifo: fall-through sync FIFO with occupancy count
module dmem_responder_fifo #(
  parameter  int W     = 33,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr,
  input  logic [W-1:0]  wdata,
  input  logic          rd,
  output logic [W-1:0]  rdata,
  output logic          vld,
  output logic [CW-1:0] cnt
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic          empty, push, deq;
  assign empty = cnt == '0;
  assign vld   = !empty | wr;
  assign rdata = empty ? wdata : mem[rp];
  assign push  = wr & !(empty & rd);
  assign deq   = rd & !empty;
  // pointer and occupancy bookkeeping; a write that bypasses an empty FIFO is never stored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp == PW'(DEPTH - 1) ? '0 : wp + 1'b1;
      if (deq) rp <= rp == PW'(DEPTH - 1) ? '0 : rp + 1'b1;
      cnt <= cnt + CW'(push) - CW'(deq);
    end
  end
  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wdata;
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: in-order load/store responder over word-organised on-chip RAM
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int MEM_WORDS  = 1024,
  parameter int LATENCY    = 1,
  parameter int RESP_DEPTH = 2
) (
  input logic clk,
  input logic rst_n,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(RESP_DEPTH + 1);
  logic              rdy, rdy_q, acc, err, we;
  logic [1:0]        len, off, m_len, m_off;
  logic [AW-1:0]     idx;
  logic [3:0]        be;
  logic [N_BITS-1:0] wd, rdata, sh;
  logic [N_BITS-1:0] ram [MEM_WORDS];
  logic              m_st, m_err;
  logic [LATENCY-1:0] pv;
  dmem_resp_t        r0, f_in, f_out;
  logic              f_vld;
  logic [CW-1:0]     f_cnt;
  assign len = bus.req_ctrl.len;
  assign off = bus.req_addr[1:0];
  assign idx = bus.req_addr[AW+1:2];
  assign acc = bus.req_ctrl.vld & rdy;
  assign err = (len == 2'd3) | (len == DMEM_LEN_H & off[0]) | (len == DMEM_LEN_W & |off)
             | (|bus.req_addr[N_BITS-1:AW+2]);
  assign we  = acc & bus.req_ctrl.mtype & !err;
  assign be  = lane_be(len, off);
  assign wd  = len == DMEM_LEN_B ? {4{bus.req_wdata[7:0]}} :
               len == DMEM_LEN_H ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
  // credit: in-flight pipeline entries plus FIFO occupancy, from registered state only
  assign rdy = rdy_q && (int'($countones(pv)) + int'(f_cnt) < RESP_DEPTH);
  assign bus.req_rdy = rdy;
  // RAM: byte-lane store merge and synchronous read on the accept edge
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) if (we && be[b]) ram[idx][8*b +: 8] <= wd[8*b +: 8];
    if (acc) rdata <= ram[idx];
  end
  // ready-after-reset flag, latency valid pipe and accept-time request metadata
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q <= 1'b0;
      pv    <= '0;
      m_st  <= 1'b0;
      m_err <= 1'b0;
      m_len <= '0;
      m_off <= '0;
    end else begin
      rdy_q <= 1'b1;
      pv    <= (pv << 1) | LATENCY'(acc);
      if (acc) begin
        m_st  <= bus.req_ctrl.mtype;
        m_err <= err;
        m_len <= len;
        m_off <= off;
      end
    end
  end
  assign sh = rdata >> {m_off, 3'b000};
  assign r0 = '{data: (m_st | m_err) ? '0 :
                      m_len == DMEM_LEN_B ? {24'd0, sh[7:0]} :
                      m_len == DMEM_LEN_H ? {16'd0, sh[15:0]} : sh,
                err: m_err};
  if (LATENCY > 1) begin : g_dly
    dmem_resp_t pr [LATENCY-1];
    // extra response delay stages; validity travels in pv
    always_ff @(posedge clk) begin
      pr[0] <= r0;
      for (int k = 1; k < LATENCY - 1; k++) pr[k] <= pr[k-1];
    end
    assign f_in = pr[LATENCY-2];
  end else begin : g_dir
    assign f_in = r0;
  end
  dmem_responder_fifo #(.W($bits(dmem_resp_t)), .DEPTH(RESP_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (pv[LATENCY-1]),
    .wdata (f_in),
    .rd    (bus.resp_rdy),
    .rdata (f_out),
    .vld   (f_vld),
    .cnt   (f_cnt)
  );
  assign bus.resp_vld  = f_vld;
  assign bus.resp_data = f_vld ? f_out.data : '0;
  assign bus.resp_err  = f_vld & f_out.err;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks against a byte-addressed memory model
module tb_dmem_responder;
  import dmem_responder_pkg::*;
  localparam int MW = 1024, LAT = 1, DEPTH = 2;
  typedef struct {
    logic [31:0] data;
    logic        err;
    int          ready;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  dmem_responder_if bus();
  dmem_responder #(.MEM_WORDS(MW), .LATENCY(LAT), .RESP_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );
  always #5 clk = ~clk;
  logic [7:0]  mm [MW*4];
  exp_t        q [$];
  int          tests = 0, fails = 0, cyc = 0, n_acc;
  logic [31:0] last;
  logic        last_err, a;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(logic mt, logic [1:0] ln, logic [31:0] ad, logic [31:0] wd);
    exp_t e;
    int n = 1 << ln;
    e.err   = ln == 2'd3 || (ad % n) != 0 || ad >= MW * 4;
    e.data  = '0;
    e.ready = cyc + LAT;
    if (!e.err)
      for (int i = 0; i < n; i++)
        if (mt) mm[ad+i] = wd[8*i +: 8];
        else e.data[8*i +: 8] = mm[ad+i];
    return e;
  endfunction
  task automatic step(input logic v, input logic mt, input logic [1:0] ln, input logic [31:0] ad,
                      input logic [31:0] wd, input logic rr, output logic acc);
    logic ev;
    bus.req_ctrl  = '{vld: v, mtype: mt, len: ln};
    bus.req_addr  = ad;
    bus.req_wdata = wd;
    bus.resp_rdy  = rr;
    #1;
    ev = q.size() > 0 && q[0].ready <= cyc;
    check("req_rdy", 32'(bus.req_rdy), 32'(q.size() < DEPTH));
    check("resp_vld", 32'(bus.resp_vld), 32'(ev));
    if (bus.resp_vld && q.size() > 0) begin
      check("resp_data", bus.resp_data, q[0].data);
      check("resp_err", 32'(bus.resp_err), 32'(q[0].err));
      if (rr) begin
        last     = q[0].data;
        last_err = q[0].err;
        void'(q.pop_front());
      end
    end
    acc = v && bus.req_rdy;
    if (acc) q.push_back(model(mt, ln, ad, wd));
    cyc++;
    @(negedge clk);
  endtask
  task automatic issue(input logic mt, input logic [1:0] ln, input logic [31:0] ad, input logic [31:0] wd);
    logic ok;
    for (int k = 0; k < 20; k++) begin
      step(1'b1, mt, ln, ad, wd, 1'b1, ok);
      if (ok) return;
    end
    tests++;
    fails++;
    $error("FAIL issue_timeout: addr %h never accepted", ad);
  endtask
  task automatic drain();
    logic x;
    for (int k = 0; k < 50 && q.size() > 0; k++) step(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b1, x);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $error("FAIL drain_timeout: %0d responses still pending, expected 0", q.size());
    end
  endtask
  initial begin
    bus.req_ctrl  = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.resp_rdy  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_req_rdy", 32'(bus.req_rdy), 32'd0);
      check("rst_resp_vld", 32'(bus.resp_vld), 32'd0);
      check("rst_resp_data", bus.resp_data, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("rdy_after_rst", 32'(bus.req_rdy), 32'd1);
    for (int w = 0; w < 16; w++) issue(1'b1, 2'd2, 32'(w * 4), $urandom);
    drain();
    issue(1'b1, 2'd2, 32'h10, 32'hDEADBEEF);
    issue(1'b0, 2'd2, 32'h10, 32'h0);
    drain();
    check("word_load", last, 32'hDEADBEEF);
    issue(1'b1, 2'd0, 32'h11, 32'h55);
    issue(1'b0, 2'd1, 32'h12, 32'h0);
    drain();
    check("half_load", last, 32'h0000DEAD);
    issue(1'b0, 2'd0, 32'h11, 32'h0);
    drain();
    check("byte_load", last, 32'h00000055);
    issue(1'b0, 2'd2, 32'h12, 32'h0);
    drain();
    check("mis_word_err", 32'(last_err), 32'd1);
    check("mis_word_data", last, 32'd0);
    issue(1'b1, 2'd1, 32'h13, 32'hFFFF);
    drain();
    check("mis_half_err", 32'(last_err), 32'd1);
    issue(1'b0, 2'd2, 32'h10, 32'h0);
    drain();
    check("word_unchanged", last, 32'hDEAD55EF);
    issue(1'b0, 2'd2, 32'h2000, 32'h0);
    drain();
    check("oor_err", 32'(last_err), 32'd1);
    n_acc = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 2'd2, 32'(32'h10 + 4 * i), 32'h0, 1'b0, a);
      n_acc += int'(a);
    end
    check("bp_accepted", 32'(n_acc), 32'd2);
    check("bp_req_rdy", 32'(bus.req_rdy), 32'd0);
    issue(1'b0, 2'd2, 32'h18, 32'h0);
    issue(1'b0, 2'd2, 32'h1C, 32'h0);
    drain();
    check("bp_last", last, {mm[32'h1F], mm[32'h1E], mm[32'h1D], mm[32'h1C]});
    step(1'b1, 1'b0, 2'd2, 32'h10, 32'h0, 1'b0, a);
    step(1'b1, 1'b0, 2'd2, 32'h14, 32'h0, 1'b0, a);
    rst_n = 1'b0;
    q.delete();
    #1;
    check("midrst_req_rdy", 32'(bus.req_rdy), 32'd0);
    check("midrst_resp_vld", 32'(bus.resp_vld), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_rdy_after", 32'(bus.req_rdy), 32'd1);
    repeat (5) step(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1, a);
    repeat (400)
      step(($urandom % 4) != 0, 1'($urandom % 2), 2'($urandom % 4),
           ($urandom % 8 == 0) ? 32'h1000 + ($urandom % 64) : $urandom % 64,
           $urandom, ($urandom % 3) != 0, a);
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
